// File: rtl/coverage_sampler.sv
// Coverage bitmap sampler: folds DUT state into a bitmap index, counts first hits, then dumps the bitmap word by word.
// Optional transition coverage is enabled with `define COVERAGE_EDGE_EN.
module coverage_sampler #(
   parameter  int WIDTH     = 32,
   parameter  int MAP_BITS  = 10,
   parameter  int CNT_WIDTH = 32,
   localparam int AW        = (MAP_BITS > 5) ? MAP_BITS - 5 : 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 sample_valid,
   input  logic [WIDTH-1:0]     state,
   input  logic                 finish,
   input  logic [CNT_WIDTH-1:0] cfg_max_cycles,
   output logic                 new_cov,
   output logic [MAP_BITS:0]    cov_count,
   output logic [CNT_WIDTH-1:0] cycle_count,
   output logic                 timeout,
   output logic                 dump_valid,
   input  logic                 dump_ready,
   output logic [AW-1:0]        dump_addr,
   output logic [31:0]          dump_data,
   output logic                 done,
   output logic [1:0]           dbg_state
);

   localparam int            WORDS = 1 << (MAP_BITS - 5);
   localparam logic [AW-1:0] LAST  = AW'(WORDS - 1);

   typedef enum logic [1:0] {
      S_CLEAR = 2'd0,
      S_RUN   = 2'd1,
      S_DUMP  = 2'd2,
      S_DONE  = 2'd3
   } fsm_t;

   fsm_t                 st;
   logic [31:0]          bitmap [WORDS];
   logic [AW-1:0]        clr_addr;
   logic [MAP_BITS-1:0]  fold_idx;
   logic [MAP_BITS-1:0]  idx;
   logic [AW-1:0]        idx_word;
   logic [4:0]           idx_bit;
   logic                 hit_bit;
   logic                 accept;
   logic                 limit_hit;
   logic                 cnt_sat;

   // XOR of successive MAP_BITS-wide slices; bit i of state lands on fold bit i mod MAP_BITS.
   function automatic logic [MAP_BITS-1:0] fold(input logic [WIDTH-1:0] s);
      logic [MAP_BITS-1:0] f;
      f = '0;
      for (int i = 0; i < WIDTH; i++) begin
         f[i % MAP_BITS] = f[i % MAP_BITS] ^ s[i];
      end
      return f;
   endfunction

   assign fold_idx = fold(state);

`ifdef COVERAGE_EDGE_EN
   logic [MAP_BITS-1:0] prev_idx;
   assign idx = fold_idx ^ (prev_idx >> 1);
`else
   assign idx = fold_idx;
`endif

   assign idx_word  = AW'(idx >> 5);
   assign idx_bit   = idx[4:0];
   assign hit_bit   = bitmap[idx_word][idx_bit];
   assign accept    = (st == S_RUN) && sample_valid;
   assign limit_hit = (cfg_max_cycles != '0) && (cycle_count >= cfg_max_cycles);
   assign cnt_sat   = (cycle_count == '1);
   assign dbg_state = st;

   // Bitmap storage carries no reset; the CLEAR sweep is what empties it.
   always_ff @(posedge clock) begin
      if (st == S_CLEAR) begin
         bitmap[clr_addr] <= '0;
      end else if (accept) begin
         bitmap[idx_word][idx_bit] <= 1'b1;
      end
   end

   // Dump handshake: a word transfers on any edge where dump_valid && dump_ready;
   // while dump_ready is low, dump_addr and dump_data hold. dump_data is zero when dump_valid is low.
   assign dump_data = dump_valid ? bitmap[dump_addr] : 32'd0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         st          <= S_CLEAR;
         clr_addr    <= '0;
         new_cov     <= 1'b0;
         cov_count   <= '0;
         cycle_count <= '0;
         timeout     <= 1'b0;
         dump_valid  <= 1'b0;
         dump_addr   <= '0;
         done        <= 1'b0;
`ifdef COVERAGE_EDGE_EN
         prev_idx    <= '0;
`endif
      end else begin
         new_cov <= 1'b0;
         case (st)
            S_CLEAR: begin
               clr_addr <= clr_addr + AW'(1);
               if (clr_addr == LAST) begin
                  st <= S_RUN;
               end
            end
            S_RUN: begin
               if (accept) begin
                  if (!hit_bit) begin
                     new_cov   <= 1'b1;
                     cov_count <= cov_count + (MAP_BITS + 1)'(1);
                  end
`ifdef COVERAGE_EDGE_EN
                  prev_idx <= fold_idx;
`endif
               end
               // finish takes priority over the cycle limit; the final RUN cycle is not counted.
               if (finish) begin
                  st         <= S_DUMP;
                  dump_valid <= 1'b1;
                  dump_addr  <= '0;
               end else if (limit_hit) begin
                  timeout    <= 1'b1;
                  st         <= S_DUMP;
                  dump_valid <= 1'b1;
                  dump_addr  <= '0;
               end else if (!cnt_sat) begin
                  cycle_count <= cycle_count + CNT_WIDTH'(1);
               end
            end
            S_DUMP: begin
               if (dump_ready) begin
                  if (dump_addr == LAST) begin
                     dump_valid <= 1'b0;
                     done       <= 1'b1;
                     st         <= S_DONE;
                  end else begin
                     dump_addr <= dump_addr + AW'(1);
                  end
               end
            end
            S_DONE: begin
               done <= 1'b1;
            end
            default: begin
               st <= S_CLEAR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_coverage_sampler.sv
// Bench for coverage_sampler: bitmap/count model with an expected queue for new_cov and dump words.
// Builds with or without COVERAGE_EDGE_EN; the model follows the same macro.
module tb_coverage_sampler;

   localparam int WIDTH     = 32;
   localparam int MAP_BITS  = 10;
   localparam int CNT_WIDTH = 32;
   localparam int AW        = MAP_BITS - 5;
   localparam int WORDS     = 1 << AW;
   localparam logic [1:0] ST_CLEAR = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DUMP  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic                 clock;
   logic                 reset;
   logic                 sample_valid;
   logic [WIDTH-1:0]     state;
   logic                 finish;
   logic [CNT_WIDTH-1:0] cfg_max_cycles;
   logic                 new_cov;
   logic [MAP_BITS:0]    cov_count;
   logic [CNT_WIDTH-1:0] cycle_count;
   logic                 timeout;
   logic                 dump_valid;
   logic                 dump_ready;
   logic [AW-1:0]        dump_addr;
   logic [31:0]          dump_data;
   logic                 done;
   logic [1:0]           dbg_state;

   logic [31:0]          exp_q[$];
   int                   vec_count = 0;
   int                   err_count = 0;
   logic [31:0]          model_map [WORDS];
   int                   model_cov;
   logic [MAP_BITS-1:0]  model_prev;
   logic [WIDTH-1:0]     last_state;

   coverage_sampler #(
      .WIDTH(WIDTH), .MAP_BITS(MAP_BITS), .CNT_WIDTH(CNT_WIDTH)
   ) dut (
      .clock(clock), .reset(reset), .sample_valid(sample_valid), .state(state),
      .finish(finish), .cfg_max_cycles(cfg_max_cycles), .new_cov(new_cov),
      .cov_count(cov_count), .cycle_count(cycle_count), .timeout(timeout),
      .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
      .dump_data(dump_data), .done(done), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [MAP_BITS-1:0] model_fold(input logic [WIDTH-1:0] s);
      logic [WIDTH+MAP_BITS-1:0] ext;
      logic [MAP_BITS-1:0]       f;
      ext = {{MAP_BITS{1'b0}}, s};
      f = '0;
      for (int j = 0; j * MAP_BITS < WIDTH; j++) f = f ^ ext[j*MAP_BITS +: MAP_BITS];
      return f;
   endfunction

   function automatic logic outs_nonzero();
      return new_cov | (|cov_count) | (|cycle_count) | timeout | dump_valid |
             (|dump_addr) | (|dump_data) | done;
   endfunction

   task automatic model_clear();
      for (int w = 0; w < WORDS; w++) model_map[w] = 32'd0;
      model_cov  = 0;
      model_prev = '0;
      exp_q.delete();
   endtask

   // ---------------- driver tasks (called #1 after a rising edge) ----------------
   task automatic drive_sample(input logic [WIDTH-1:0] s);
      logic [MAP_BITS-1:0] f;
      logic [MAP_BITS-1:0] ix;
      f = model_fold(s);
`ifdef COVERAGE_EDGE_EN
      ix = f ^ (model_prev >> 1);
`else
      ix = f;
`endif
      exp_q.push_back(model_map[ix[MAP_BITS-1:5]][ix[4:0]] ? 32'd0 : 32'd1);
      if (!model_map[ix[MAP_BITS-1:5]][ix[4:0]]) model_cov++;
      model_map[ix[MAP_BITS-1:5]][ix[4:0]] = 1'b1;
      model_prev = f;
      last_state = s;
      sample_valid = 1'b1;
      state = s;
      @(posedge clock); #1;
      sample_valid = 1'b0;
   endtask

   task automatic drive_idle();
      @(posedge clock); #1;
   endtask

   task automatic wait_run();
      int n;
      n = 0;
      while (dbg_state !== ST_RUN && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      if (dbg_state !== ST_RUN) begin
         vec_count++; err_count++;
         $display("FAIL wait_run: state=%0d after %0d cycles, required %0d", dbg_state, n, ST_RUN);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #2;
      reset = 1'b1;
      model_clear();
      wait_run();
   endtask

   // ---------------- scenario tasks ----------------
   task automatic test_reset();
      int   n;
      logic bad;
      model_clear();
      reset = 1'b0;
      #1;
      vec_count++;
      if (outs_nonzero() !== 1'b0 || dbg_state !== ST_CLEAR) begin
         err_count++;
         $display("FAIL reset_outputs: nonzero=%0b state=%0d, required 0/%0d", outs_nonzero(), dbg_state, ST_CLEAR);
      end
      @(posedge clock); #1;
      reset = 1'b1;
      n = 0;
      bad = 1'b0;
      while (dbg_state === ST_CLEAR && n < 100) begin
         if (outs_nonzero() !== 1'b0) bad = 1'b1;
         sample_valid = 1'b1;
         state = $urandom;
         finish = n[0];
         @(posedge clock); #1;
         n++;
      end
      sample_valid = 1'b0;
      finish = 1'b0;
      vec_count++;
      if (n !== 32) begin
         err_count++;
         $display("FAIL clear_length: %0d cycles, required 32", n);
      end
      vec_count++;
      if (bad !== 1'b0) begin
         err_count++;
         $display("FAIL clear_outputs: nonzero output seen=%0b, required 0", bad);
      end
      vec_count++;
      if (dbg_state !== ST_RUN || outs_nonzero() !== 1'b0) begin
         err_count++;
         $display("FAIL run_entry: state=%0d nonzero=%0b, required %0d/0", dbg_state, outs_nonzero(), ST_RUN);
      end
   endtask

   task automatic test_basic();
      logic [31:0] e;
      logic [31:0] pat [3];
      pat[0] = 32'h5; pat[1] = 32'h5; pat[2] = 32'h6;
      for (int i = 0; i < 3; i++) begin
         drive_sample(pat[i]);
         e = exp_q.pop_front();
         vec_count++;
         if (new_cov !== e[0]) begin
            err_count++;
            $display("FAIL basic_new_cov[%0d]: got %0b, required %0b", i, new_cov, e[0]);
         end
      end
      vec_count++;
      if (cov_count !== (MAP_BITS+1)'(model_cov)) begin
         err_count++;
         $display("FAIL basic_cov_count: got %0d, required %0d", cov_count, model_cov);
      end
`ifndef COVERAGE_EDGE_EN
      vec_count++;
      if (cov_count !== 11'd2) begin
         err_count++;
         $display("FAIL basic_cov_count_two: got %0d, required 2", cov_count);
      end
`endif
   endtask

   task automatic test_random();
      logic [31:0] e;
      int          r;
      for (int i = 0; i < 80; i++) begin
         r = $urandom_range(0, 3);
         if (r == 0) begin
            drive_idle();
            vec_count++;
            if (new_cov !== 1'b0) begin
               err_count++;
               $display("FAIL random_idle_new_cov[%0d]: got %0b, required 0", i, new_cov);
            end
         end else begin
            drive_sample((r == 1) ? last_state : 32'($urandom_range(0, 4095)) ^ ($urandom << 12));
            e = exp_q.pop_front();
            vec_count++;
            if (new_cov !== e[0]) begin
               err_count++;
               $display("FAIL random_new_cov[%0d]: got %0b, required %0b", i, new_cov, e[0]);
            end
         end
      end
      vec_count++;
      if (cov_count !== (MAP_BITS+1)'(model_cov)) begin
         err_count++;
         $display("FAIL random_cov_count: got %0d, required %0d", cov_count, model_cov);
      end
   endtask

   task automatic test_dump();
      logic [31:0]   e;
      logic [AW-1:0] exp_addr;
      logic [3:0]    ready_pat;
      logic [MAP_BITS:0] cov_hold;
      int            cyc;
      ready_pat = 4'b1001;
      finish = 1'b1;
      drive_sample(32'h0000_0ABC);
      finish = 1'b0;
      e = exp_q.pop_front();
      vec_count++;
      if (new_cov !== e[0]) begin
         err_count++;
         $display("FAIL finish_sample_new_cov: got %0b, required %0b", new_cov, e[0]);
      end
      vec_count++;
      if (dbg_state !== ST_DUMP || dump_valid !== 1'b1 || dump_addr !== '0) begin
         err_count++;
         $display("FAIL dump_entry: state=%0d valid=%0b addr=%0d, required %0d/1/0", dbg_state, dump_valid, dump_addr, ST_DUMP);
      end
      cov_hold = cov_count;
      for (int w = 0; w < WORDS; w++) exp_q.push_back(model_map[w]);
      exp_addr = '0;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 400) begin
         dump_ready = ready_pat[cyc % 4];
         sample_valid = 1'b1;
         state = $urandom;
         finish = 1'b1;
         vec_count++;
         if ({dump_valid, dump_addr, dump_data} !== {1'b1, exp_addr, exp_q[0]}) begin
            err_count++;
            $display("FAIL dump_word[%0d]: valid=%0b addr=%0d data=%h, required 1/%0d/%h", cyc, dump_valid, dump_addr, dump_data, exp_addr, exp_q[0]);
         end
         @(posedge clock); #1;
         if (dump_ready) begin
            e = exp_q.pop_front();
            exp_addr = exp_addr + AW'(1);
         end
         cyc++;
      end
      dump_ready = 1'b0;
      finish = 1'b0;
      vec_count++;
      if (exp_q.size() != 0) begin
         err_count++;
         $display("FAIL dump_drain: %0d words left after %0d cycles, required 0", exp_q.size(), cyc);
         exp_q.delete();
      end
      vec_count++;
      if ({done, dump_valid, dump_data} !== {1'b1, 1'b0, 32'd0} || dbg_state !== ST_DONE) begin
         err_count++;
         $display("FAIL dump_done: done=%0b valid=%0b data=%h state=%0d, required 1/0/0/%0d", done, dump_valid, dump_data, dbg_state, ST_DONE);
      end
      drive_idle();
      drive_idle();
      sample_valid = 1'b0;
      vec_count++;
      if (done !== 1'b1 || cov_count !== cov_hold || new_cov !== 1'b0) begin
         err_count++;
         $display("FAIL done_hold: done=%0b cov=%0d new=%0b, required 1/%0d/0", done, cov_count, new_cov, cov_hold);
      end
   endtask

   task automatic test_reset_mid_dump();
      logic [31:0] e;
      int          n;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         drive_sample($urandom);
         e = exp_q.pop_front();
      end
      finish = 1'b1;
      drive_idle();
      finish = 1'b0;
      dump_ready = 1'b1;
      n = 0;
      while (dump_addr !== AW'(7) && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      dump_ready = 1'b0;
      vec_count++;
      if (dump_addr !== AW'(7) || dump_valid !== 1'b1) begin
         err_count++;
         $display("FAIL mid_dump_addr: addr=%0d valid=%0b, required 7/1", dump_addr, dump_valid);
      end
      reset = 1'b0;
      #1;
      vec_count++;
      if (outs_nonzero() !== 1'b0 || dbg_state !== ST_CLEAR) begin
         err_count++;
         $display("FAIL mid_dump_reset: nonzero=%0b state=%0d, required 0/%0d", outs_nonzero(), dbg_state, ST_CLEAR);
      end
      #1;
      reset = 1'b1;
      model_clear();
      wait_run();
      finish = 1'b1;
      drive_idle();
      finish = 1'b0;
      dump_ready = 1'b1;
      for (int w = 0; w < WORDS; w++) exp_q.push_back(model_map[w]);
      n = 0;
      while (exp_q.size() > 0 && n < 100) begin
         vec_count++;
         if (dump_valid !== 1'b1 || dump_data !== exp_q[0]) begin
            err_count++;
            $display("FAIL post_reset_word[%0d]: valid=%0b data=%h, required 1/%h", n, dump_valid, dump_data, exp_q[0]);
         end
         @(posedge clock); #1;
         e = exp_q.pop_front();
         n++;
      end
      dump_ready = 1'b0;
      vec_count++;
      if (done !== 1'b1) begin
         err_count++;
         $display("FAIL post_reset_done: got %0b, required 1", done);
      end
   endtask

   task automatic test_timeout();
      int n;
      cfg_max_cycles = 32'd100;
      do_reset();
      vec_count++;
      if (cycle_count !== '0) begin
         err_count++;
         $display("FAIL timeout_start_count: got %0d, required 0", cycle_count);
      end
      n = 0;
      while (timeout !== 1'b1 && n < 300) begin
         @(posedge clock); #1;
         n++;
      end
      vec_count++;
      if (n !== 101 || cycle_count !== 32'd100 || dbg_state !== ST_DUMP) begin
         err_count++;
         $display("FAIL timeout_hit: cycles=%0d count=%0d state=%0d, required 101/100/%0d", n, cycle_count, dbg_state, ST_DUMP);
      end
      dump_ready = 1'b1;
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      dump_ready = 1'b0;
      vec_count++;
      if (done !== 1'b1 || timeout !== 1'b1 || cycle_count !== 32'd100) begin
         err_count++;
         $display("FAIL timeout_sticky: done=%0b timeout=%0b count=%0d, required 1/1/100", done, timeout, cycle_count);
      end
   endtask

   task automatic test_finish_vs_timeout();
      int n;
      cfg_max_cycles = 32'd50;
      do_reset();
      n = 0;
      while (cycle_count !== 32'd50 && n < 200) begin
         @(posedge clock); #1;
         n++;
      end
      finish = 1'b1;
      drive_idle();
      finish = 1'b0;
      vec_count++;
      if (timeout !== 1'b0 || dbg_state !== ST_DUMP) begin
         err_count++;
         $display("FAIL finish_wins: timeout=%0b state=%0d, required 0/%0d", timeout, dbg_state, ST_DUMP);
      end
      cfg_max_cycles = '0;
   endtask

`ifdef COVERAGE_EDGE_EN
   task automatic test_edge();
      logic [31:0] e;
      logic [2:0]  exp_pat;
      exp_pat = 3'b011;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive_sample(32'h3);
         e = exp_q.pop_front();
         vec_count++;
         if (new_cov !== exp_pat[i]) begin
            err_count++;
            $display("FAIL edge_new_cov[%0d]: got %0b, required %0b", i, new_cov, exp_pat[i]);
         end
      end
   endtask
`endif

   // ---------------- sequence and report ----------------
   initial begin
      reset = 1'b0;
      sample_valid = 1'b0;
      state = '0;
      finish = 1'b0;
      cfg_max_cycles = '0;
      dump_ready = 1'b0;
      last_state = '0;
      test_reset();
      test_basic();
      test_random();
      test_dump();
      test_reset_mid_dump();
      test_timeout();
      test_finish_vs_timeout();
`ifdef COVERAGE_EDGE_EN
      test_edge();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
      $finish;
   end

endmodule

// File: doc/coverage_sampler.md
COVERAGE_SAMPLER -- requirements
Module: coverage_sampler

Interface
REQ-001 SHALL have parameter WIDTH, default 32, width of the sampled DUT state vector.
REQ-002 SHALL have parameter MAP_BITS, default 10, log2 of bitmap entries; legal range 5..16.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, width of the cycle counter and timeout limit.
REQ-004 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 SHALL have port sample_valid  input  1  state is a valid sample this cycle.
REQ-007 SHALL have port state  input  WIDTH  DUT state vector to record.
REQ-008 SHALL have port finish  input  1  test-end request from the harness.
REQ-009 SHALL have port cfg_max_cycles  input  CNT_WIDTH  timeout limit; 0 disables timeout.
REQ-010 SHALL have port new_cov  output  1  one-cycle pulse: previously unseen bitmap entry hit.
REQ-011 SHALL have port cov_count  output  MAP_BITS+1  number of distinct entries hit.
REQ-012 SHALL have port cycle_count  output  CNT_WIDTH  RUN cycles elapsed, saturating.
REQ-013 SHALL have port timeout  output  1  run ended by cycle limit, sticky.
REQ-014 SHALL have port dump_valid  output  1  dump_data/dump_addr valid.
REQ-015 SHALL have port dump_ready  input  1  consumer accepts the current dump word.
REQ-016 SHALL have port dump_addr  output  MAP_BITS-5  bitmap word index being dumped.
REQ-017 SHALL have port dump_data  output  32  bitmap word; bit i = entry dump_addr*32+i.
REQ-018 SHALL have port done  output  1  dump complete, held until reset.

Function
REQ-019 SHALL hold a bitmap of 2^MAP_BITS bits organised as 2^(MAP_BITS-5) 32-bit words, without per-bit reset.
REQ-020 SHALL implement FSM states CLEAR, RUN, DUMP, DONE; reset release enters CLEAR.
REQ-021 CLEAR SHALL zero one bitmap word per cycle, addresses 0 upward, then enter RUN the cycle after the last word; samples and finish during CLEAR are ignored.
REQ-022 Fold index SHALL be the XOR of consecutive MAP_BITS-bit slices of state starting at bit 0, last slice zero-padded.
REQ-023 In RUN with sample_valid=1 the block SHALL set the indexed bit at the next edge; if it was 0, new_cov=1 and cov_count+1 on that edge, else new_cov=0.
REQ-024 Back-to-back samples to the same entry SHALL yield exactly one new_cov pulse and one cov_count increment.
REQ-025 cycle_count SHALL increment every RUN cycle and saturate at all-ones.
REQ-026 In RUN, finish=1 SHALL enter DUMP at the next edge; a sample in the same cycle is still recorded.
REQ-027 In RUN, cfg_max_cycles!=0 and cycle_count>=cfg_max_cycles SHALL set timeout and enter DUMP; if finish is also 1 that cycle, finish wins and timeout stays 0.
REQ-028 In DUMP dump_valid SHALL be 1, dump_addr starts at 0 and advances only when dump_valid&&dump_ready; dump_data/dump_addr stable while stalled.
REQ-029 Acceptance of the last word SHALL enter DONE: dump_valid=0, done=1; samples and finish ignored in DUMP and DONE.

Reset
REQ-030 reset=0 SHALL immediately force state CLEAR, new_cov=0, cov_count=0, cycle_count=0, timeout=0, dump_valid=0, dump_addr=0, done=0, previous index=0, from any state including mid-DUMP.
REQ-031 dump_data SHALL be 0 whenever dump_valid=0.

Configuration
REQ-032 With COVERAGE_EDGE_EN defined, index SHALL be fold(state) XOR (prev_index>>1), prev_index updating to the fold value on each accepted RUN sample (transition coverage).
REQ-033 Without COVERAGE_EDGE_EN, index SHALL be fold(state) only and no prev_index register SHALL exist.

Verification
REQ-034 Reset release, MAP_BITS=10 -> RUN reached after exactly 32 CLEAR cycles; all outputs 0 meanwhile.
REQ-035 Macro off, samples state=0x5,0x5,0x6 consecutive -> new_cov pattern 1,0,1; cov_count=2.
REQ-036 cfg_max_cycles=100, no finish -> timeout=1 with cycle_count=100; DUMP entered; finish asserted with limit hit same cycle -> timeout=0.
REQ-037 DUMP with dump_ready toggling 1,0,0,1 -> dump_addr/dump_data hold during stalls; done=1 after word 31 accepted; dumped bits match samples.
REQ-038 reset=0 asserted mid-DUMP at dump_addr=7 -> outputs zero immediately; CLEAR restarts; prior coverage absent from next dump.
REQ-039 Macro on, state=0x3 twice then 0x3 -> indices 3,2,2: new_cov 1,1,0.
